// File: rtl/norm_row_collector_pkg.sv
// Shared definitions for the normalizer row collector: default element width,
// row geometry, row-sequence index width and the row-pair FIFO entry layout.
// No ports; imported by norm_row_collector and its FIFO.
package norm_row_collector_pkg;

  localparam int BW_PSUM_DEF = 11;  // 2*bw+3 with bw=4
  localparam int COL_DEF     = 8;   // elements per row per core
  localparam int DEPTH_DEF   = 4;   // row-pair FIFO entries
  localparam int ROW_W       = COL_DEF * BW_PSUM_DEF;
  localparam int IDX_W       = 8;   // row sequence number, wraps at 256

  // Row-pair FIFO entry. Packed order puts idx at the MSBs, then row_2,
  // with row_1 at the LSBs; the top builds the same layout by concatenation
  // so that non-default COL/BW_PSUM values keep the identical ordering.
  typedef struct packed {
    logic [IDX_W-1:0] idx;
    logic [ROW_W-1:0] row_2;
    logic [ROW_W-1:0] row_1;
  } row_pair_t;

endpackage

// File: rtl/norm_row_collector_fifo.sv
// sync_fifo_fwft: generic first-word-fall-through FIFO; head visible on dout_o
// while not empty. Latency: a push is visible at the head one cycle later.
// Backpressure: push on full is ignored unless a pop happens on the same edge.
// Ports: clk_i/rst_ni clock and async active-low reset, clr_i sync flush,
//        push_i/din_i write, pop_i read, dout_o head, full_o/empty_o/level_o status.
module sync_fifo_fwft #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     clr_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         din_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         dout_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic             do_push, do_pop;

  assign full_o  = (level_q == LW'(DEPTH));
  assign empty_o = (level_q == '0);
  assign level_o = level_q;
  assign dout_o  = mem_q[rd_ptr_q];

  // A push into a full FIFO succeeds only when the head leaves on the same edge.
  assign do_pop  = pop_i && !empty_o && !clr_i;
  assign do_push = push_i && !clr_i && (!full_o || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (clr_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      // Pointers wrap naturally because DEPTH is a power of two.
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level_d = level_q + 1'b1;
        2'b01:   level_d = level_q - 1'b1;
        default: level_d = level_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage needs no reset: entries are only observed after being written.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

endmodule

// File: rtl/norm_row_collector.sv
// norm_row_collector: assembles COL normalizer beats per core into row pairs,
// buffers them in a FWFT FIFO and drains them over out_valid/out_ready.
// Latency: last beat of a row into an empty FIFO -> out_valid the next cycle.
// Backpressure: none toward the normalizer; a completed row that finds the FIFO
// full (with no pop on that edge) is dropped and sets the sticky overflow flag.
// Ports: clk/reset (async active-low), clear (sync flush), norm_valid +
//        psum_norm_1/2 beats in, out_valid/out_ready + out_row_1/2/out_row_idx
//        out, fifo_level occupancy, overflow sticky drop flag.
module norm_row_collector
  import norm_row_collector_pkg::*;
#(
  parameter int BW_PSUM = BW_PSUM_DEF,
  parameter int COL     = COL_DEF,
  parameter int DEPTH   = DEPTH_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     norm_valid,
  input  logic [BW_PSUM-1:0]       psum_norm_1,
  input  logic [BW_PSUM-1:0]       psum_norm_2,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [COL*BW_PSUM-1:0]   out_row_1,
  output logic [COL*BW_PSUM-1:0]   out_row_2,
  output logic [IDX_W-1:0]         out_row_idx,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic                     overflow
);

  localparam int RW = COL * BW_PSUM;
  localparam int CW = $clog2(COL);
  localparam int EW = 2 * RW + IDX_W;
  localparam logic [CW-1:0] LAST_BEAT = CW'(COL - 1);

  logic [CW-1:0]    beat_q, beat_d;
  logic [IDX_W-1:0] row_idx_q, row_idx_d;
  logic [RW-1:0]    asm_1_q, asm_1_d;
  logic [RW-1:0]    asm_2_q, asm_2_d;
  logic             overflow_q, overflow_d;

  logic [RW-1:0]    row_1_m, row_2_m;
  logic             beat_acc, last_beat, row_done, pop;
  logic             fifo_full, fifo_empty;
  logic [EW-1:0]    fifo_din, fifo_dout;

  // A beat is discarded when clear coincides with it.
  assign beat_acc  = norm_valid && !clear;
  assign last_beat = (beat_q == LAST_BEAT);
  assign row_done  = beat_acc && last_beat;
  assign pop       = out_valid && out_ready && !clear;

  // Merge the incoming beat into the assembly image so the completing beat
  // can be pushed on the same edge it arrives.
  always_comb begin
    row_1_m = asm_1_q;
    row_2_m = asm_2_q;
    row_1_m[BW_PSUM*int'(beat_q) +: BW_PSUM] = psum_norm_1;
    row_2_m[BW_PSUM*int'(beat_q) +: BW_PSUM] = psum_norm_2;
  end

  always_comb begin
    beat_d     = beat_q;
    row_idx_d  = row_idx_q;
    asm_1_d    = asm_1_q;
    asm_2_d    = asm_2_q;
    overflow_d = overflow_q;
    if (clear) begin
      beat_d     = '0;
      row_idx_d  = '0;
      overflow_d = 1'b0;
    end else if (norm_valid) begin
      asm_1_d = row_1_m;
      asm_2_d = row_2_m;
      if (last_beat) begin
        beat_d = '0;
        // The index advances even for a dropped row, leaving a visible gap.
        row_idx_d = row_idx_q + 1'b1;
        if (fifo_full && !pop) overflow_d = 1'b1;
      end else begin
        beat_d = beat_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      beat_q     <= '0;
      row_idx_q  <= '0;
      asm_1_q    <= '0;
      asm_2_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      beat_q     <= beat_d;
      row_idx_q  <= row_idx_d;
      asm_1_q    <= asm_1_d;
      asm_2_q    <= asm_2_d;
      overflow_q <= overflow_d;
    end
  end

  // Entry layout matches row_pair_t: idx at MSBs, row_1 at LSBs.
  assign fifo_din = {row_idx_q, row_2_m, row_1_m};

  sync_fifo_fwft #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .rst_ni  (reset),
    .clr_i   (clear),
    .push_i  (row_done),
    .din_i   (fifo_din),
    .pop_i   (pop),
    .dout_o  (fifo_dout),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_level)
  );

  assign out_valid = !fifo_empty;
  assign overflow  = overflow_q;

  // Head data is zeroed while empty so the outputs read 0 straight out of
  // reset without resetting the FIFO storage.
  assign out_row_1   = out_valid ? fifo_dout[RW-1:0]        : '0;
  assign out_row_2   = out_valid ? fifo_dout[2*RW-1:RW]     : '0;
  assign out_row_idx = out_valid ? fifo_dout[EW-1:2*RW]     : '0;

endmodule

// File: tb/tb_norm_row_collector.sv
module tb_norm_row_collector;

  localparam int BW    = 11;
  localparam int COL   = 8;
  localparam int DEPTH = 4;
  localparam int RW    = COL * BW;

  logic          clk = 1'b0;
  logic          reset;
  logic          clear;
  logic          norm_valid;
  logic [BW-1:0] psum_norm_1;
  logic [BW-1:0] psum_norm_2;
  logic          out_valid;
  logic          out_ready;
  logic [RW-1:0] out_row_1;
  logic [RW-1:0] out_row_2;
  logic [7:0]    out_row_idx;
  logic [2:0]    fifo_level;
  logic          overflow;

  int n_checks = 0;
  int n_errors = 0;

  norm_row_collector #(.BW_PSUM(BW), .COL(COL), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .reset       (reset),
    .clear       (clear),
    .norm_valid  (norm_valid),
    .psum_norm_1 (psum_norm_1),
    .psum_norm_2 (psum_norm_2),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_row_1   (out_row_1),
    .out_row_2   (out_row_2),
    .out_row_idx (out_row_idx),
    .fifo_level  (fifo_level),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // All driving and sampling happens 1ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [BW-1:0] a, input logic [BW-1:0] b);
    norm_valid  = 1'b1;
    psum_norm_1 = a;
    psum_norm_2 = b;
    tick();
    norm_valid  = 1'b0;
  endtask

  // Row with base B: core-1 element k = B+k, core-2 element k = B+k+3.
  task automatic push_row(input int base);
    for (int k = 0; k < COL; k++) beat(BW'(base + k), BW'(base + k + 3));
  endtask

  function automatic logic [RW-1:0] row_of(input int base, input int off);
    logic [RW-1:0] r;
    r = '0;
    for (int k = 0; k < COL; k++) r[k*BW +: BW] = BW'(base + k + off);
    return r;
  endfunction

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  logic [RW-1:0] exp1, exp2;

  initial begin
    reset       = 1'b0;
    clear       = 1'b0;
    norm_valid  = 1'b0;
    psum_norm_1 = '0;
    psum_norm_2 = '0;
    out_ready   = 1'b0;

    // Reset state
    #3;
    check("rst_valid", out_valid, 0);
    check("rst_level", fifo_level, 0);
    check("rst_ovf", overflow, 0);
    check("rst_idx", out_row_idx, 0);
    check("rst_row1", out_row_1, 0);
    check("rst_row2", out_row_2, 0);
    tick();
    reset = 1'b1;
    tick();

    // Basic row
    out_ready = 1'b1;
    exp1 = '0;
    exp2 = '0;
    for (int k = 0; k < COL; k++) begin
      exp1[k*BW +: BW] = BW'(k + 1);
      exp2[k*BW +: BW] = BW'(12'h7F0 + k);
    end
    for (int k = 0; k < COL; k++) begin
      if (k == COL - 1) check("basic_no_early", out_valid, 0);
      beat(BW'(k + 1), BW'(12'h7F0 + k));
    end
    check("basic_valid", out_valid, 1);
    check("basic_row1", out_row_1, exp1);
    check("basic_row2", out_row_2, exp2);
    check("basic_idx", out_row_idx, 0);
    tick();
    check("basic_popped", out_valid, 0);

    // Gapped beats: same data, idx 1
    for (int k = 0; k < COL; k++) begin
      beat(BW'(k + 1), BW'(12'h7F0 + k));
      if (k < COL - 1) begin
        check("gap_no_early", out_valid, 0);
        repeat ($urandom_range(5, 0)) tick();
      end
    end
    check("gap_valid", out_valid, 1);
    check("gap_row1", out_row_1, exp1);
    check("gap_row2", out_row_2, exp2);
    check("gap_idx", out_row_idx, 1);
    tick();

    // Fill and overflow
    out_ready = 1'b0;
    do_clear();
    for (int r = 0; r < 4; r++) push_row(r * 16);
    check("fill_level4", fifo_level, 4);
    check("fill_ovf0", overflow, 0);
    push_row(4 * 16);
    check("ovf_level", fifo_level, 4);
    check("ovf_set", overflow, 1);
    out_ready = 1'b1;
    for (int r = 0; r < 4; r++) begin
      check("drain_valid", out_valid, 1);
      check("drain_idx", out_row_idx, r);
      check("drain_row1", out_row_1, row_of(r * 16, 0));
      check("drain_row2", out_row_2, row_of(r * 16, 3));
      tick();
    end
    check("drain_empty", fifo_level, 0);
    out_ready = 1'b0;
    push_row(12'h100);
    check("gap_idx5", out_row_idx, 5);
    check("ovf_sticky", overflow, 1);

    // Full with simultaneous pop
    do_clear();
    check("clear_ovf", overflow, 0);
    check("clear_level", fifo_level, 0);
    for (int r = 0; r < 4; r++) push_row(12'h200 + r * 16);
    for (int k = 0; k < COL - 1; k++) beat(BW'(12'h240 + k), BW'(12'h243 + k));
    out_ready = 1'b1;
    beat(BW'(12'h247), BW'(12'h24A));
    check("fullpop_ovf", overflow, 0);
    check("fullpop_level", fifo_level, 4);
    for (int r = 1; r < 5; r++) begin
      check("fullpop_idx", out_row_idx, r);
      check("fullpop_row1", out_row_1, row_of(12'h200 + r * 16, 0));
      tick();
    end
    check("fullpop_empty", out_valid, 0);

    // Clear mid-row with a coincident beat
    for (int k = 0; k < 3; k++) beat(BW'(12'h155), BW'(12'h155));
    clear = 1'b1;
    beat(BW'(12'h2AA), BW'(12'h2AA));
    clear = 1'b0;
    for (int k = 0; k < COL; k++) begin
      beat(BW'(12'h600 + k), BW'(12'h603 + k));
      if (k < COL - 1) check("clr_no_early", out_valid, 0);
    end
    check("clr_valid", out_valid, 1);
    check("clr_idx", out_row_idx, 0);
    check("clr_ovf", overflow, 0);
    check("clr_row1", out_row_1, row_of(12'h600, 0));
    check("clr_row2", out_row_2, row_of(12'h600, 3));
    tick();
    check("clr_one_row", out_valid, 0);

    // Async reset mid-operation
    out_ready = 1'b0;
    do_clear();
    for (int r = 0; r < 5; r++) push_row(12'h400 + r * 16);
    out_ready = 1'b1;
    tick();
    tick();
    out_ready = 1'b0;
    check("pre_rst_level", fifo_level, 2);
    check("pre_rst_ovf", overflow, 1);
    check("pre_rst_idx", out_row_idx, 2);
    for (int k = 0; k < 4; k++) beat(BW'(12'h500 + k), BW'(12'h500 + k));
    #2;
    reset = 1'b0;
    #1;
    check("arst_valid", out_valid, 0);
    check("arst_level", fifo_level, 0);
    check("arst_ovf", overflow, 0);
    check("arst_idx", out_row_idx, 0);
    tick();
    reset = 1'b1;
    push_row(12'h300);
    check("post_rst_valid", out_valid, 1);
    check("post_rst_idx", out_row_idx, 0);
    check("post_rst_row1", out_row_1, row_of(12'h300, 0));
    check("post_rst_row2", out_row_2, row_of(12'h300, 3));
    check("post_rst_level", fifo_level, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
